// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampled SPI slave with rx valid/ack handshake and daisy-chain pass-through
module spi_slave_sync #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LOAD,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_ACK,
  output logic              BUSY,
  output logic              OVERRUN
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_d, ss_d, sck_s, ss_s, mosi_s;
  logic lead, trail, smp_edge, shf_edge, ss_fall, ss_rise;
  logic start, stop, do_smp, do_shf, done;
  logic [DATA_W-1:0] tx_buf, sr;
  logic [CW-1:0] bitcnt;
  logic smp, sampled;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sck_q[0]  <= SCK;
      ss_q[0]   <= SS;
      mosi_q[0] <= MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_q[i]  <= sck_q[i-1];
        ss_q[i]   <= ss_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
      end
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign lead     = (sck_s != sck_d) && (sck_d == CKP);
  assign trail    = (sck_s != sck_d) && (sck_s == CKP);
  assign smp_edge = CPH ? trail : lead;
  assign shf_edge = CPH ? lead : trail;
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;

  always_ff @(posedge CLK) state <= RESET ? IDLE : state_nx;

  always_comb state_nx = (state == IDLE) ? (ss_fall ? SHIFT : IDLE) : (ss_rise ? IDLE : SHIFT);

  // an SS rise masks any SCK edge seen in the same cycle
  always_comb begin
    start  = (state == IDLE) && ss_fall;
    stop   = (state == SHIFT) && ss_rise;
    do_smp = (state == SHIFT) && !ss_rise && smp_edge;
    do_shf = (state == SHIFT) && !ss_rise && shf_edge && sampled;
    done   = do_smp && (bitcnt == LAST);
    BUSY   = (state == SHIFT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_buf   <= '0;
      sr       <= '0;
      bitcnt   <= '0;
      smp      <= 1'b0;
      sampled  <= 1'b0;
      MISO     <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (TX_LOAD) tx_buf <= TX_DATA;
      if (start) begin
        sr      <= tx_buf;
        bitcnt  <= '0;
        sampled <= 1'b0;
        MISO    <= tx_buf[DATA_W-1];
      end
      if (stop) MISO <= 1'b0;
      if (do_smp) begin
        smp     <= mosi_s;
        sampled <= 1'b1;
        bitcnt  <= (bitcnt == LAST) ? '0 : bitcnt + 1'b1;
      end
      // sr keeps shifting past a word boundary so earlier bits flow out for chaining
      if (do_shf) begin
        sr   <= {sr[DATA_W-2:0], smp};
        MISO <= sr[DATA_W-2];
      end
      if (done) begin
        RX_DATA  <= {sr[DATA_W-2:0], mosi_s};
        RX_VALID <= 1'b1;
        if (RX_VALID && !RX_ACK) OVERRUN <= 1'b1;
      end else if (RX_ACK) begin
        RX_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master driving one or two chained slaves, scoreboarded rx words
module tb_spi_slave_sync;
  localparam int HALF = 8;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst, ckp, cph, ss, sck, mosi, tx_load, rx_ack, chain;
  logic [15:0] tx_data;
  logic miso1, miso2, rx_valid1, rx_valid2, busy1, busy2, ovr1, ovr2;
  logic [15:0] rx_data1, rx_data2;
  logic ss2, miso_m;
  logic [31:0] r;
  logic [15:0] q1[$], q2[$];
  int checks = 0, errors = 0, rises1 = 0, r0;

  assign ss2    = chain ? ss : 1'b1;
  assign miso_m = chain ? miso2 : miso1;

  always #5 clk = ~clk;

  spi_slave_sync #(.DATA_W(16), .SYNC_STAGES(SYNC)) u1 (
    .CLK(clk), .RESET(rst), .CKP(ckp), .CPH(cph), .SS(ss), .SCK(sck), .MOSI(mosi),
    .MISO(miso1), .TX_DATA(tx_data), .TX_LOAD(tx_load), .RX_DATA(rx_data1),
    .RX_VALID(rx_valid1), .RX_ACK(rx_ack), .BUSY(busy1), .OVERRUN(ovr1));

  spi_slave_sync #(.DATA_W(16), .SYNC_STAGES(SYNC)) u2 (
    .CLK(clk), .RESET(rst), .CKP(ckp), .CPH(cph), .SS(ss2), .SCK(sck), .MOSI(miso1),
    .MISO(miso2), .TX_DATA(tx_data), .TX_LOAD(tx_load), .RX_DATA(rx_data2),
    .RX_VALID(rx_valid2), .RX_ACK(rx_ack), .BUSY(busy2), .OVERRUN(ovr2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon1();
    logic pv = 1'b0;
    logic [15:0] pd = '0, e;
    forever begin
      @(negedge clk);
      if (rx_valid1 === 1'b1 && (!pv || rx_data1 != pd)) begin
        if (!pv) rises1++;
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx1_word: got %h, none expected", rx_data1);
        end else begin
          e = q1.pop_front();
          chk("rx1_word", {16'h0, rx_data1}, {16'h0, e});
        end
      end
      pv = rx_valid1;
      pd = rx_data1;
    end
  endtask

  task automatic mon2();
    logic pv = 1'b0;
    logic [15:0] pd = '0, e;
    forever begin
      @(negedge clk);
      if (rx_valid2 === 1'b1 && (!pv || rx_data2 != pd)) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx2_word: got %h, none expected", rx_data2);
        end else begin
          e = q2.pop_front();
          chk("rx2_word", {16'h0, rx_data2}, {16'h0, e});
        end
      end
      pv = rx_valid2;
      pd = rx_data2;
    end
  endtask

  // optional ack pulse lands on the cycle the slave registers a word completed by the edge just driven
  task automatic half(input bit ack_here);
    for (int c = 0; c < HALF; c++) begin
      @(negedge clk);
      if (ack_here && c == SYNC - 1) rx_ack = 1'b1;
      if (c == SYNC) rx_ack = 1'b0;
    end
  endtask

  task automatic bits(input int n, input logic [31:0] w, input bit ack_last, output logic [31:0] rr);
    rr = '0;
    if (!cph) mosi = w[n-1];
    for (int i = 0; i < n; i++) begin
      if (!cph) begin
        sck = ~ckp;
        rr = {rr[30:0], miso_m};
        half(ack_last && i == n - 1);
        sck = ckp;
        if (i < n - 1) mosi = w[n-2-i];
        half(1'b0);
      end else begin
        sck = ~ckp;
        mosi = w[n-1-i];
        half(1'b0);
        sck = ckp;
        rr = {rr[30:0], miso_m};
        half(ack_last && i == n - 1);
      end
    end
  endtask

  task automatic xfer(input int n, input logic [31:0] w, input bit ack_last, output logic [31:0] rr);
    if (!cph) mosi = w[n-1];
    ss = 1'b0;
    half(1'b0);
    chk("busy_mid", {31'h0, busy1}, 32'h1);
    bits(n, w, ack_last, rr);
    half(1'b0);
    ss = 1'b1;
    half(1'b0);
    half(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_miso"}, {31'h0, miso1}, 32'h0);
    chk({tag, "_rx_data"}, {16'h0, rx_data1}, 32'h0);
    chk({tag, "_rx_valid"}, {31'h0, rx_valid1}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy1}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, ovr1}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ckp = 1'b0; cph = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; rx_ack = 1'b0; chain = 1'b0; tx_data = '0;
    fork
      mon1();
      mon2();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    // mode 0
    load(16'hA5C3);
    r0 = rises1;
    q1.push_back(16'h3C5A);
    xfer(16, 32'h3C5A, 1'b0, r);
    chk("m0_master_rx", r, 32'h0000A5C3);
    chk("m0_valid_rises", rises1 - r0, 32'h1);
    chk("m0_busy_after", {31'h0, busy1}, 32'h0);
    chk("m0_miso_idle", {31'h0, miso1}, 32'h0);
    ack();
    chk("m0_valid_acked", {31'h0, rx_valid1}, 32'h0);
    // mode 3
    ckp = 1'b1; cph = 1'b1; sck = 1'b1;
    do_reset();
    load(16'h8001);
    q1.push_back(16'hFFFE);
    xfer(16, 32'hFFFE, 1'b0, r);
    chk("m3_master_rx", r, 32'h00008001);
    chk("m3_rx_data", {16'h0, rx_data1}, 32'h0000FFFE);
    ack();
    // truncated frame then a full one
    ckp = 1'b0; cph = 1'b0; sck = 1'b0;
    do_reset();
    xfer(9, 32'h1FF, 1'b0, r);
    chk("part_rx_valid", {31'h0, rx_valid1}, 32'h0);
    chk("part_miso", {31'h0, miso1}, 32'h0);
    q1.push_back(16'h1234);
    xfer(16, 32'h1234, 1'b0, r);
    chk("part_next_rx", {16'h0, rx_data1}, 32'h00001234);
    ack();
    // daisy chain
    chain = 1'b1;
    do_reset();
    q1.push_back(16'hDEAD);
    q1.push_back(16'hBEEF);
    q2.push_back(16'h0000);
    q2.push_back(16'hDEAD);
    xfer(32, 32'hDEADBEEF, 1'b0, r);
    chk("chain_master_rx", r, 32'h00000000);
    chk("chain_rx2", {16'h0, rx_data2}, 32'h0000DEAD);
    chain = 1'b0;
    // overrun without and with ack on the completion cycle
    do_reset();
    q1.push_back(16'h1111);
    q1.push_back(16'h2222);
    xfer(16, 32'h1111, 1'b0, r);
    xfer(16, 32'h2222, 1'b0, r);
    chk("ovr_flag", {31'h0, ovr1}, 32'h1);
    chk("ovr_rx_data", {16'h0, rx_data1}, 32'h00002222);
    do_reset();
    q1.push_back(16'h3333);
    q1.push_back(16'h4444);
    xfer(16, 32'h3333, 1'b0, r);
    xfer(16, 32'h4444, 1'b1, r);
    chk("ack_ovr_flag", {31'h0, ovr1}, 32'h0);
    chk("ack_rx_valid", {31'h0, rx_valid1}, 32'h1);
    chk("ack_rx_data", {16'h0, rx_data1}, 32'h00004444);
    // reset in mid-frame with SS held low
    mosi = 1'b1;
    ss = 1'b0;
    half(1'b0);
    bits(5, 32'h15, 1'b0, r);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    bits(16, 32'hFFFF, 1'b0, r);
    half(1'b0);
    chk("midrst_no_valid", {31'h0, rx_valid1}, 32'h0);
    chk("midrst_no_busy", {31'h0, busy1}, 32'h0);
    ss = 1'b1;
    half(1'b0);
    half(1'b0);
    q1.push_back(16'h5A5A);
    xfer(16, 32'h5A5A, 1'b0, r);
    ack();
    repeat (4) @(negedge clk);
    chk("q1_drained", q1.size(), 32'h0);
    chk("q2_drained", q2.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Synchronous SPI slave endpoint: the counterpart of the SPI master transmitter, running entirely in the system `CLK` domain and oversampling the `SCK`, `SS` and `MOSI` pins. It receives `DATA_W`-bit MSB-first words into a parallel register with a valid/ack handshake, and shifts a preloaded response word out on `MISO`. Bits beyond `DATA_W` in one frame are passed through, so instances can be daisy-chained MOSI→MISO behind a single master chip select.

## Interface
- `DATA_W`, default 16: word and frame length in bits.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `SCK`, `SS` and `MOSI`.

- `CLK`  in  1  system clock. This is the only clock.
- `RESET`  in  1  synchronous, active-high reset.
- `CKP`  in  1  clock polarity; this is the idle level of `SCK`. Static while `SS` is low.
- `CPH`  in  1  clock phase. 0 samples on the leading edge; 1 samples on the trailing edge.
- `SS`  in  1  slave select, active low, asynchronous to `CLK`.
- `SCK`  in  1  serial clock from the master, asynchronous.
- `MOSI`  in  1  serial data in, asynchronous.
- `MISO`  out  1  serial data out, registered. Drives 0 while the slave is not selected.
- `TX_DATA`  in  `DATA_W`  response word.
- `TX_LOAD`  in  1  one-cycle strobe that captures `TX_DATA` into `tx_buf`.
- `RX_DATA`  out  `DATA_W`  last complete received word.
- `RX_VALID`  out  1  `RX_DATA` holds an unacknowledged word.
- `RX_ACK`  in  1  consumer acknowledge. Clears `RX_VALID`.
- `BUSY`  out  1  a frame is in progress.
- `OVERRUN`  out  1  sticky flag: a word completed while `RX_VALID` was still 1.

## Operation
- **Input synchronization:** `SCK`, `SS` and `MOSI` each pass through `SYNC_STAGES` flip-flops. One extra register on `SCK` and `SS` provides edge detection.
- **Edge definitions:**
  - A leading edge is `SCK` leaving `CKP`.
  - A trailing edge is `SCK` returning to `CKP`.
  - The sample edge is the leading edge when `CPH`=0 and the trailing edge when `CPH`=1.
  - The shift edge is the opposite edge type.
- **FSM, two states:**
  - IDLE → SHIFT on a detected falling edge of `SS`. On this transition: `sr` <= `tx_buf`, `bitcnt` <= 0, `MISO` <= `tx_buf[DATA_W-1]`, `BUSY` <= 1.
  - SHIFT → IDLE on a detected rising edge of `SS`. On this transition: `BUSY` <= 0 and `MISO` <= 0. A partial word is discarded and `RX_VALID` does not assert.
- **Sample edge in SHIFT:**
  - `smp` <= synchronized `MOSI`.
  - `bitcnt` <= `bitcnt`+1, wrapping from `DATA_W`-1 to 0.
  - If `bitcnt` = `DATA_W`-1, the word is complete: `RX_DATA` <= {`sr[DATA_W-2:0]`, `MOSI`} and `RX_VALID` <= 1.
- **Shift edge in SHIFT:**
  - The shift happens only if at least one sample has been taken since the `SS` fall. This means the first leading edge is ignored when `CPH`=1.
  - `sr` <= {`sr[DATA_W-2:0]`, `smp`}; `MISO` <= `sr[DATA_W-2]`.
- **Daisy chain:** `sr` is not reloaded when `bitcnt` wraps. After `DATA_W` bits, `MISO` outputs the bits received earlier, delayed by `DATA_W`.
- **RX handshake:**
  - `RX_ACK` with `RX_VALID`=1 clears `RX_VALID` on the next cycle.
  - If a word completes in the same cycle as `RX_ACK`, `RX_VALID` stays 1, new data is loaded, and `OVERRUN` is not set.
  - If a word completes while `RX_VALID`=1 and no ack is present: `OVERRUN` <= 1 and `RX_DATA` is overwritten.
- **TX load:** `TX_LOAD` updates `tx_buf` in any state. A load during SHIFT takes effect at the next `SS` fall only.
- **Simultaneous events:** if an `SS` rise and an `SCK` edge are detected in the same cycle, the `SS` rise wins and the `SCK` edge is ignored.

## Timing
- **Reset values:** `MISO`=0, `RX_DATA`=0, `RX_VALID`=0, `BUSY`=0, `OVERRUN`=0, `tx_buf`=0, `sr`=0, `bitcnt`=0, FSM=IDLE, synchronizers = 0.
- **Reset mid-frame:** returns to IDLE immediately. The frame is not resumed, even if `SS` stays low. A new frame needs a fresh `SS` fall.
- **Detection latency:** a pin edge is detected `SYNC_STAGES`+1 `CLK` cycles after it occurs.
- **Output latency:** `MISO`, `RX_VALID` and `RX_DATA` update one cycle after detection.
- **Constraints on the master:**
  - `SCK` high and low times must each be ≥ `SYNC_STAGES`+3 `CLK` cycles.
  - `SS` setup before the first `SCK` edge must be ≥ `SYNC_STAGES`+3 cycles.
  - `SS` hold after the last `SCK` edge must be ≥ `SYNC_STAGES`+3 cycles.
- **`MISO` validity:** `MISO` is stable before the master's sample edge whenever the constraints above hold.

## Test plan
- Mode 0 (`CKP`=0, `CPH`=0), `tx_buf`=0xA5C3, master sends 0x3C5A → master receives 0xA5C3; `RX_DATA`=0x3C5A; `RX_VALID` rises exactly once; `BUSY` falls after `SS` rise.
- Mode 3 (`CKP`=1, `CPH`=1), `tx_buf`=0x8001, master sends 0xFFFE → master receives 0x8001; `RX_DATA`=0xFFFE; the first leading edge causes no shift.
- `SS` raised after 9 bits → `RX_VALID` stays 0 and `MISO`=0. The next full frame of 0x1234 → `RX_DATA`=0x1234.
- Two instances chained, 32-bit frame 0xDEAD_BEEF, both `tx_buf`=0x0000 → first instance `RX_DATA` sequence is 0xDEAD then 0xBEEF; second instance gets 0xDEAD; master `MISO` returns 0x0000_0000.
- Two back-to-back words with no `RX_ACK` → `OVERRUN`=1 and `RX_DATA` holds the second word. Repeat with `RX_ACK` on the completion cycle → `OVERRUN`=0.
- `RESET` asserted after 5 bits with `SS` held low → all outputs return to reset values next cycle; no frame resumes until `SS` toggles.
